lsu_r32i: RTL and testbench

- Load/store unit between the single-cycle core's execute stage (ALU address, rs2 data, decoder controls) and the word-wide data RAM port.
- Implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW on a 32-bit word RAM with 1-cycle registered read latency:
  - sub-word loads extract and extend the addressed lane;
  - sub-word stores perform read-modify-write.
- Stalls the PC via LsuStall until the access completes.
- Yields the RAM port to the instruction cache while RAMBusy is high.

---
 rtl/lsu_r32i.sv | 154 +++++++++++++++
 tb/tb_lsu_r32i.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_r32i.sv
// RV32I load/store unit between execute and the word-wide data RAM.
// Sub-word loads are extracted and extended; sub-word stores are read-modify-write.

module lsu_r32i #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 30
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   MemReq,
    input  logic                   MemWrite,
    input  logic [2:0]             Funct3,
    input  logic [dataW-1:0]       Addr,
    input  logic [dataW-1:0]       StoreData,
    input  logic                   RAMBusy,
    input  logic [dataW-1:0]       RAMOut,
    output logic                   LsuStall,
    output logic [dataW-1:0]       LoadData,
    output logic                   MisalignFault,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       RAMDataIn,
    output logic                   RAMWriteControl
);
    localparam int LANES = dataW / 8;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    // The word address lives in RAMAddr and SW data in RAMDataIn, so only the
    // fields still needed after leaving IDLE are held here.
    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [1:0]  byteOff;
        logic [15:0] storeLo;
    } lsuReqT;

    logic [2:0]             state, nextState;
    lsuReqT                 req;
    logic                   isWord, isHalf, illegal, misalign, reqBad, start;
    logic [dataW-1:0]       laneShift, loadExt, merged;
    logic [LANES-1:0][7:0]  ramLanes, mergedLanes;

    assign isWord   = (Funct3 == 3'b010);
    assign isHalf   = (Funct3[1:0] == 2'b01);
    assign illegal  = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11) ||
                      (MemWrite && (Funct3[2:1] == 2'b10));
    assign misalign = (isWord && (Addr[1:0] != 2'b00)) || (isHalf && Addr[0]);
    assign reqBad   = illegal || misalign;
    assign start    = MemReq && !RAMBusy;

    assign LsuStall        = MemReq && (state != DONE) && !reset;
    assign RAMWriteControl = (state == WR) && !RAMBusy && !reset;

    // Load path: shift the addressed lane down to bit 0, then extend.
    assign laneShift = RAMOut >> {req.byteOff, 3'b000};

    always_comb begin
        loadExt = laneShift;
        case (req.funct3)
            3'b000:  loadExt = {{(dataW-8){laneShift[7]}}, laneShift[7:0]};
            3'b001:  loadExt = {{(dataW-16){laneShift[15]}}, laneShift[15:0]};
            3'b100:  loadExt = {{(dataW-8){1'b0}}, laneShift[7:0]};
            3'b101:  loadExt = {{(dataW-16){1'b0}}, laneShift[15:0]};
            default: loadExt = laneShift;
        endcase
    end

    // Store merge: only SB/SH reach CAP as writes, so funct3[0] alone marks a half.
    assign ramLanes = RAMOut;
    generate
        for (genvar k = 0; k < LANES; k++) begin : gLane
            lsu_r32i_lane #(.LANE(k)) uLane (
                .byteOff   (req.byteOff),
                .isHalf    (req.funct3[0]),
                .storeByte (((k % 2) == 1 && req.funct3[0]) ? req.storeLo[15:8]
                                                            : req.storeLo[7:0]),
                .ramByte   (ramLanes[k]),
                .mergedByte(mergedLanes[k])
            );
        end
    endgenerate
    assign merged = mergedLanes;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) begin
                if (reqBad)                  nextState = DONE;
                else if (MemWrite && isWord) nextState = WR;
                else                         nextState = RD;
            end
            RD:      if (!RAMBusy) nextState = CAP;
            CAP:     nextState = req.write ? WR : DONE;
            WR:      if (!RAMBusy) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            req           <= '0;
            LoadData      <= '0;
            MisalignFault <= 1'b0;
            RAMAddr       <= '0;
            RAMDataIn     <= '0;
        end else begin
            state         <= nextState;
            MisalignFault <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    req.write   <= MemWrite;
                    req.funct3  <= Funct3;
                    req.byteOff <= Addr[1:0];
                    req.storeLo <= StoreData[15:0];
                    if (reqBad) begin
                        MisalignFault <= 1'b1;
                        if (!MemWrite) LoadData <= '0;
                    end else begin
                        RAMAddr <= Addr[RAMAddrSize+1:2];
                        if (MemWrite && isWord) RAMDataIn <= StoreData;
                    end
                end
                CAP: begin
                    if (req.write) RAMDataIn <= merged;
                    else           LoadData  <= loadExt;
                end
                default: ;
            endcase
        end
    end
endmodule

// One byte lane of the store merge: takes the store byte when the access covers this lane.
module lsu_r32i_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] byteOff,
    input  logic       isHalf,
    input  logic [7:0] storeByte,
    input  logic [7:0] ramByte,
    output logic [7:0] mergedByte
);
    localparam logic [1:0] IDX = 2'(LANE);

    logic sel;
    assign sel        = isHalf ? (byteOff[1] == IDX[1]) : (byteOff == IDX);
    assign mergedByte = sel ? storeByte : ramByte;
endmodule

// File: tb/tb_lsu_r32i.sv
// Scoreboard bench for lsu_r32i: directed test-plan cases plus randomized traffic.
module tb_lsu_r32i;
    logic        clock = 1'b0;
    logic        reset, MemReq, MemWrite, RAMBusy;
    logic [2:0]  Funct3;
    logic [31:0] Addr, StoreData, RAMOut, LoadData, RAMDataIn;
    logic [29:0] RAMAddr;
    logic        LsuStall, MisalignFault, RAMWriteControl;

    lsu_r32i #(.dataW(32), .RAMAddrSize(30)) dut (
        .clock(clock), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
        .Funct3(Funct3), .Addr(Addr), .StoreData(StoreData), .RAMBusy(RAMBusy),
        .RAMOut(RAMOut), .LsuStall(LsuStall), .LoadData(LoadData),
        .MisalignFault(MisalignFault), .RAMAddr(RAMAddr), .RAMDataIn(RAMDataIn),
        .RAMWriteControl(RAMWriteControl)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] ld; bit fault; int lat; int start; } doneT;
    typedef struct { logic [29:0] addr; logic [31:0] data; int cyc; } wrT;

    doneT        doneQ[$];
    wrT          wrQ[$];
    int          checks = 0, failures = 0, cyc = 0, doneCnt = 0;
    logic [31:0] curLd = 32'h0;
    logic [31:0] refMem [0:1023];
    logic [31:0] mem [0:1023];
    logic        memInit = 1'b1;

    function automatic logic [31:0] initWord(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Data RAM with one-cycle registered read.
    always @(posedge clock) begin
        if (memInit) for (int i = 0; i < 1024; i++) mem[i] <= initWord(i);
        else if (RAMWriteControl) mem[RAMAddr[9:0]] <= RAMDataIn;
        RAMOut <= mem[RAMAddr[9:0]];
    end

    always @(negedge clock) begin : monitor
        doneT d;
        wrT   w;
        if (RAMWriteControl) begin
            checks++;
            if (RAMBusy) begin
                failures++;
                $display("FAIL write_during_busy: got strobe with RAMBusy=1, required none");
            end else if (wrQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", RAMAddr, RAMDataIn);
            end else begin
                w = wrQ.pop_front();
                if (RAMAddr !== w.addr || RAMDataIn !== w.data || (w.cyc >= 0 && cyc != w.cyc)) begin
                    failures++;
                    $display("FAIL write: got addr %h data %h cyc %0d, required addr %h data %h cyc %0d",
                             RAMAddr, RAMDataIn, cyc, w.addr, w.data, w.cyc);
                end
            end
        end
        if (!reset && MemReq && !LsuStall) begin
            doneCnt++;
            checks++;
            if (doneQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got completion, required none");
            end else begin
                d = doneQ.pop_front();
                if (LoadData !== d.ld || MisalignFault !== d.fault) begin
                    failures++;
                    $display("FAIL done_result: got ld %h fault %b, required ld %h fault %b",
                             LoadData, MisalignFault, d.ld, d.fault);
                end
                checks++;
                if (d.lat >= 0 && (cyc - d.start) != d.lat) begin
                    failures++;
                    $display("FAIL latency: got %0d, required %0d", cyc - d.start, d.lat);
                end
            end
        end else if (!reset && MisalignFault) begin
            checks++;
            failures++;
            $display("FAIL stray_fault: got MisalignFault=1 outside completion, required 0");
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Issue one access at posedge+1; model result is queued before the DUT can answer.
    task automatic access(input bit wr, input bit [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input bit rnd, input int bs, input int bl);
        logic [31:0] word, sh, ld;
        bit   bad, got;
        int   lat, woff, idx, snap;
        doneT de;
        wrT   we;
        idx  = int'(a[11:2]);
        word = refMem[idx];
        ld   = curLd;
        woff = -1;
        bad  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (wr && (f3 == 3'd4 || f3 == 3'd5)) ||
               (f3 == 3'd2 && a[1:0] != 2'b00) || ((f3 == 3'd1 || f3 == 3'd5) && a[0]);
        if (bad) begin
            lat = 1;
            if (!wr) ld = 32'h0;
        end else if (!wr) begin
            sh = word >> (8 * a[1:0]);
            case (f3)
                3'd0:    ld = 32'($signed(sh[7:0]));
                3'd1:    ld = 32'($signed(sh[15:0]));
                3'd4:    ld = {24'h0, sh[7:0]};
                3'd5:    ld = {16'h0, sh[15:0]};
                default: ld = word;
            endcase
            lat = 3;
        end else if (f3 == 3'd2) begin
            word = d; woff = 1; lat = 2;
        end else begin
            if (f3 == 3'd0) word[8*a[1:0] +: 8]  = d[7:0];
            else            word[8*a[1:0] +: 16] = d[15:0];
            woff = 3; lat = 4;
        end
        curLd = ld;
        if (woff > 0) refMem[idx] = word;
        MemReq = 1'b1; MemWrite = wr; Funct3 = f3; Addr = a; StoreData = d;
        de.ld = ld; de.fault = bad; de.lat = rnd ? -1 : lat + bl; de.start = cyc;
        doneQ.push_back(de);
        if (woff > 0) begin
            we.addr = a[31:2]; we.data = word; we.cyc = rnd ? -1 : cyc + woff + bl;
            wrQ.push_back(we);
        end
        snap = doneCnt;
        got  = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            RAMBusy = rnd ? ($urandom_range(0, 2) == 0) : (k >= bs && k < bs + bl);
            @(posedge clock); #1;
            if (doneCnt != snap) got = 1'b1;
        end
        RAMBusy = 1'b0;
        MemReq  = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL timeout: got no completion in 300 cycles, required completion (addr %h)", a);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "access timed out");
        end
    endtask

    task automatic gap(input int n);
        MemReq = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
        Addr = 32'h0; StoreData = 32'h0; RAMBusy = 1'b0;
        for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);
        @(posedge clock); #1; memInit = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_loaddata", LoadData, 32'h0);
        chk("rst_fault", 32'(MisalignFault), 32'h0);
        chk("rst_ramaddr", 32'(RAMAddr), 32'h0);
        chk("rst_ramdatain", RAMDataIn, 32'h0);
        chk("rst_wctl", 32'(RAMWriteControl), 32'h0);
        chk("rst_stall", 32'(LsuStall), 32'h0);
        @(posedge clock); #1;

        // Sub-word loads
        access(1, 3'd2, 32'h100, 32'h8081_F0F7, 0, 0, 0); gap(1);
        access(0, 3'd0, 32'h103, 32'h0, 0, 0, 0);         chk("lb_103", LoadData, 32'hFFFF_FF80); gap(1);
        access(0, 3'd4, 32'h103, 32'h0, 0, 0, 0);         chk("lbu_103", LoadData, 32'h0000_0080); gap(1);
        access(0, 3'd1, 32'h102, 32'h0, 0, 0, 0);         chk("lh_102", LoadData, 32'hFFFF_8081);
        access(0, 3'd5, 32'h102, 32'h0, 0, 0, 0);         chk("lhu_102", LoadData, 32'h0000_8081);
        access(0, 3'd2, 32'h100, 32'h0, 0, 0, 0);         chk("lw_100", LoadData, 32'h8081_F0F7); gap(2);
        // Read-modify-write stores
        access(1, 3'd2, 32'h200, 32'h1122_3344, 0, 0, 0); gap(1);
        access(1, 3'd0, 32'h201, 32'h0000_00AB, 0, 0, 0); gap(1);
        access(1, 3'd1, 32'h202, 32'h0000_BEEF, 0, 0, 0); gap(1);
        access(0, 3'd2, 32'h200, 32'h0, 0, 0, 0);         chk("lw_200", LoadData, 32'hBEEF_AB44); gap(1);
        access(1, 3'd2, 32'h300, 32'hDEAD_BEEF, 0, 0, 0);
        access(0, 3'd2, 32'h300, 32'h0, 0, 0, 0);         chk("lw_300", LoadData, 32'hDEAD_BEEF); gap(1);
        // Rejected accesses
        access(0, 3'd2, 32'h102, 32'h0, 0, 0, 0);         chk("lw_mis_ld", LoadData, 32'h0); gap(1);
        access(1, 3'd1, 32'h101, 32'h0000_1234, 0, 0, 0);
        access(0, 3'd3, 32'h100, 32'h0, 0, 0, 0);
        access(1, 3'd4, 32'h100, 32'h0000_0055, 0, 0, 0);
        access(0, 3'd1, 32'h103, 32'h0, 0, 0, 0);         gap(1);
        // SB with RAMBusy high for three cycles while in RD
        access(1, 3'd0, 32'h205, 32'h0000_005C, 0, 1, 3); gap(1);
        access(0, 3'd2, 32'h204, 32'h0, 0, 0, 0);         gap(1);

        // Reset lands in CAP of an SB: nothing may be written
        MemReq = 1'b1; MemWrite = 1'b1; Funct3 = 3'd0; Addr = 32'h209; StoreData = 32'h66; RAMBusy = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1; MemReq = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0; curLd = 32'h0;
        @(negedge clock);
        chk("rst2_loaddata", LoadData, 32'h0);
        chk("rst2_fault", 32'(MisalignFault), 32'h0);
        chk("rst2_ramaddr", 32'(RAMAddr), 32'h0);
        chk("rst2_ramdatain", RAMDataIn, 32'h0);
        chk("rst2_wctl", 32'(RAMWriteControl), 32'h0);
        chk("rst2_stall", 32'(LsuStall), 32'h0);
        @(posedge clock); #1;
        access(0, 3'd2, 32'h208, 32'h0, 0, 0, 0); gap(1);

        // Randomized traffic: fixed-latency phase, then random RAMBusy
        for (int n = 0; n < 150; n++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'h100 + 32'($urandom_range(0, 63)), $urandom, 0, 0, 0);
            gap($urandom_range(0, 2));
        end
        for (int n = 0; n < 150; n++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'h100 + 32'($urandom_range(0, 63)), $urandom, 1, 0, 0);
            gap($urandom_range(0, 2));
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("doneq_empty", 32'(doneQ.size()), 32'h0);
        chk("wrq_empty", 32'(wrQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
